// File: rtl/wt_pingpong_buffer_pkg.sv
// wt_buf_pkg: shared loader state encoding, default geometry and the write-time parity helper
package wt_buf_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FULL} ld_state_e;
  localparam int NUM_BANKS_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_DEPTH_DEF = 2048;
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/wt_pingpong_buffer_if.sv
// wt_pingpong_buffer_if: loader stream, swap control and read port of the weight buffer (rd_perr only with WT_BUF_PARITY_EN)
interface wt_pingpong_buffer_if #(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic                            csen;
  logic                            load_start;
  logic [ADDR_WIDTH:0]             load_len;
  logic                            s_valid;
  logic                            s_ready;
  logic [NUM_BANKS*DATA_WIDTH-1:0] s_data;
  logic                            load_done;
  logic                            shadow_full;
  logic                            swap;
  logic                            swap_err;
  logic                            rd_en;
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data;
  logic                            rd_valid;
  logic                            active_sel;
`ifdef WT_BUF_PARITY_EN
  logic [NUM_BANKS-1:0]            rd_perr;
`endif
  modport master (
    output csen, load_start, load_len, s_valid, s_data, swap, rd_en, rd_addr,
    input  s_ready, load_done, shadow_full, swap_err, rd_data, rd_valid, active_sel
`ifdef WT_BUF_PARITY_EN
    , input rd_perr
`endif
  );
  modport slave (
    input  csen, load_start, load_len, s_valid, s_data, swap, rd_en, rd_addr,
    output s_ready, load_done, shadow_full, swap_err, rd_data, rd_valid, active_sel
`ifdef WT_BUF_PARITY_EN
    , output rd_perr
`endif
  );
endinterface

// File: rtl/wt_pingpong_buffer_bank_ram.sv
// wt_bank_ram: simple dual-port RAM, one write port and one registered read port, contents never reset
module wt_bank_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic             re_i,
  input  logic [AW-1:0]    ra_i,
  output logic [WIDTH-1:0] rd_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;
  assign rd_o = rd_q;
  // write and registered read share the clock; halves never collide so no bypass
  always_ff @(posedge clk) begin
    if (we_i) mem[wa_i] <= wd_i;
    if (re_i) rd_q <= mem[ra_i];
  end
endmodule

// File: rtl/wt_pingpong_buffer.sv
// wt_pingpong_buffer: double-buffered multi-bank weight store; WT_BUF_PARITY_EN adds per-word even parity and rd_perr
module wt_pingpong_buffer
  import wt_buf_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_DEPTH = DATA_DEPTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  wt_pingpong_buffer_if.slave bus
);
`ifdef WT_BUF_PARITY_EN
  localparam int W = DATA_WIDTH + 1;
`else
  localparam int W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DATA_DEPTH);

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  active_sel_q, active_sel_d;
  logic                  load_done_q, load_done_d;
  logic                  swap_err_q, swap_err_d;
  logic                  rd_valid_q;
  logic                  beat, last, len_ok, re;
  logic [ADDR_WIDTH:0]   wa, ra;
  logic [W-1:0]          ram_q [NUM_BANKS];

  // half 1 lives in the upper DATA_DEPTH words of each bank
  function automatic logic [ADDR_WIDTH:0] phys(input logic half, input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} + (half ? DEPTH_W : '0);
  endfunction

  assign beat   = state_q == LOAD && bus.csen && bus.s_valid;
  assign last   = {1'b0, wr_cnt_q} == len_q - 1'b1;
  assign len_ok = bus.load_len != '0 && bus.load_len <= DEPTH_W;
  assign re     = bus.rd_en && bus.csen;
  assign wa     = phys(~active_sel_q, wr_cnt_q);
  assign ra     = phys(active_sel_q, bus.rd_addr);

  assign bus.s_ready     = state_q == LOAD && bus.csen;
  assign bus.shadow_full = state_q == FULL;
  assign bus.load_done   = load_done_q;
  assign bus.swap_err    = swap_err_q;
  assign bus.active_sel  = active_sel_q;
  assign bus.rd_valid    = rd_valid_q;

  // loader next state: fill the shadow half, then wait for a swap
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    len_d        = len_q;
    active_sel_d = active_sel_q;
    load_done_d  = 1'b0;
    swap_err_d   = bus.swap && state_q != FULL;
    case (state_q)
      IDLE: if (bus.load_start && len_ok) begin
        state_d  = LOAD;
        wr_cnt_d = '0;
        len_d    = bus.load_len;
      end
      LOAD: if (beat) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (last) begin
          state_d     = FULL;
          load_done_d = 1'b1;
        end
      end
      FULL: if (bus.swap) begin
        state_d      = IDLE;
        active_sel_d = ~active_sel_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // loader and read-pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      len_q        <= '0;
      active_sel_q <= 1'b0;
      load_done_q  <= 1'b0;
      swap_err_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      len_q        <= len_d;
      active_sel_q <= active_sel_d;
      load_done_q  <= load_done_d;
      swap_err_q   <= swap_err_d;
      rd_valid_q   <= re;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] w;
    logic [W-1:0]          wd;
    assign w = bus.s_data[b*DATA_WIDTH +: DATA_WIDTH];
`ifdef WT_BUF_PARITY_EN
    assign wd = {even_parity(64'(w)), w};
`else
    assign wd = w;
`endif
    wt_bank_ram #(.WIDTH(W), .DEPTH(2*DATA_DEPTH), .AW(ADDR_WIDTH+1)) u_ram (
      .clk(clk), .we_i(beat), .wa_i(wa), .wd_i(wd), .re_i(re), .ra_i(ra), .rd_o(ram_q[b])
    );
  end

  // read data is forced to zero whenever no read was issued last cycle
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_valid_q ? ram_q[i][DATA_WIDTH-1:0] : '0;
  end

`ifdef WT_BUF_PARITY_EN
  // stored word plus parity must xor to zero; anything else is a flipped bit
  always_comb begin
    bus.rd_perr = '0;
    for (int i = 0; i < NUM_BANKS; i++) bus.rd_perr[i] = rd_valid_q && (^ram_q[i]);
  end
`endif
endmodule

// File: tb/tb_wt_pingpong_buffer.sv
// tb_wt_pingpong_buffer: directed plus randomized checks against a half-level behavioural model of the buffer
module tb_wt_pingpong_buffer;
  localparam int NB = 4, DW = 8, AW = 11, DEPTH = 2048, BW = NB*DW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wt_pingpong_buffer_if #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  wt_pingpong_buffer #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0, checks = 0;
  logic [BW-1:0] mdl [2][DEPTH];
  bit known [2][DEPTH];
  bit [NB-1:0] bad [2][DEPTH];
  bit m_loading, m_full, m_act;
  int m_cnt, m_len;
  logic [BW-1:0] e_rd_data;
  bit e_rd_valid, e_known, e_load_done, e_swap_err;
  bit [NB-1:0] e_perr;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    if (m_loading) for (int i = 0; i < DEPTH; i++) known[m_act ? 0 : 1][i] = 1'b0;
    m_loading = 0; m_full = 0; m_act = 0;
    e_rd_valid = 0; e_known = 0; e_rd_data = '0; e_load_done = 0; e_swap_err = 0; e_perr = '0;
  endtask

  task automatic model_step();
    int sh;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_rd_valid  = bus.rd_en && bus.csen;
    e_known     = e_rd_valid && known[m_act][bus.rd_addr];
    e_rd_data   = e_rd_valid ? mdl[m_act][bus.rd_addr] : '0;
    e_perr      = e_rd_valid ? bad[m_act][bus.rd_addr] : '0;
    e_swap_err  = bus.swap && !m_full;
    e_load_done = 0;
    sh = m_act ? 0 : 1;
    if (m_loading) begin
      if (bus.s_valid && bus.csen) begin
        mdl[sh][m_cnt] = bus.s_data;
        known[sh][m_cnt] = 1'b1;
        bad[sh][m_cnt] = '0;
        m_cnt++;
        if (m_cnt == m_len) begin
          m_loading = 0; m_full = 1; e_load_done = 1;
        end
      end
    end else if (m_full) begin
      if (bus.swap) begin
        m_act = !m_act; m_full = 0;
      end
    end else if (bus.load_start && int'(bus.load_len) >= 1 && int'(bus.load_len) <= DEPTH) begin
      m_loading = 1; m_cnt = 0; m_len = int'(bus.load_len);
    end
  endtask

  task automatic compare();
    chk("s_ready", 64'(bus.s_ready), 64'(m_loading && bus.csen));
    chk("load_done", 64'(bus.load_done), 64'(e_load_done));
    chk("shadow_full", 64'(bus.shadow_full), 64'(m_full));
    chk("swap_err", 64'(bus.swap_err), 64'(e_swap_err));
    chk("active_sel", 64'(bus.active_sel), 64'(m_act));
    chk("rd_valid", 64'(bus.rd_valid), 64'(e_rd_valid));
    if (!e_rd_valid || e_known) chk("rd_data", 64'(bus.rd_data), 64'(e_rd_data));
`ifdef WT_BUF_PARITY_EN
    chk("rd_perr", 64'(bus.rd_perr), 64'(e_perr));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clr();
    bus.csen = 1; bus.load_start = 0; bus.load_len = '0; bus.s_valid = 0; bus.s_data = '0;
    bus.swap = 0; bus.rd_en = 0; bus.rd_addr = '0;
  endtask

  initial begin
    int k, r;
    bit sent;
    clr();
    bus.csen = 0;
    model_reset();
    repeat (3) cyc();
    rst_n = 1;
    bus.rd_en = 1;
    cyc();
    chk("rst rd_data", 64'(bus.rd_data), 64'(0));
    chk("rst rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst active_sel", 64'(bus.active_sel), 64'(0));
    chk("rst shadow_full", 64'(bus.shadow_full), 64'(0));
    bus.csen = 1;
    #1;
    chk("idle s_ready", 64'(bus.s_ready), 64'(0));
    cyc();
    chk("rd_valid lit", 64'(bus.rd_valid), 64'(1));

    clr(); bus.load_start = 1; bus.load_len = 12'd4;
    cyc();
    chk("s_ready after start", 64'(bus.s_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      clr(); bus.s_valid = 1; bus.s_data = 32'h04030201 + i;
      cyc();
      if (i == 2) chk("load_done early", 64'(bus.load_done), 64'(0));
    end
    chk("load_done cycle5", 64'(bus.load_done), 64'(1));
    chk("shadow_full lit", 64'(bus.shadow_full), 64'(1));
    clr(); cyc();
    chk("load_done pulse", 64'(bus.load_done), 64'(0));
    bus.swap = 1; cyc();
    chk("swap active_sel", 64'(bus.active_sel), 64'(1));
    chk("swap shadow_full", 64'(bus.shadow_full), 64'(0));
    for (int i = 0; i < 4; i++) begin
      clr(); bus.rd_en = 1; bus.rd_addr = 11'(i);
      cyc();
      chk("read lit", 64'(bus.rd_data), 64'(32'h04030201 + i));
    end

    clr(); bus.load_start = 1; bus.load_len = 12'd3; cyc();
    clr(); bus.swap = 1; cyc();
    chk("swap_err lit", 64'(bus.swap_err), 64'(1));
    chk("swap_err active_sel", 64'(bus.active_sel), 64'(1));
    k = 0;
    for (int t = 0; t < 60 && !bus.shadow_full; t++) begin
      clr();
      sent = 1'($urandom % 2);
      bus.s_valid = sent;
      bus.s_data = 32'hCAFE0000 + k;
      bus.rd_en = 1;
      bus.rd_addr = 11'($urandom_range(0, 3));
      r = int'(bus.rd_addr);
      cyc();
      chk("read during load", 64'(bus.rd_data), 64'(32'h04030201 + r));
      if (sent) k++;
    end
    chk("load finished", 64'(bus.shadow_full), 64'(1));
    clr(); bus.swap = 1; bus.rd_en = 1; cyc();
    chk("swap+read old half", 64'(bus.rd_data), 64'(32'h04030201));
    chk("swap back", 64'(bus.active_sel), 64'(0));
    clr(); bus.rd_en = 1; cyc();
    chk("read new half", 64'(bus.rd_data), 64'(32'hCAFE0000));
    clr(); bus.load_start = 1; bus.load_len = 12'd0; cyc();
    chk("len0 s_ready", 64'(bus.s_ready), 64'(0));
    clr(); bus.load_start = 1; bus.load_len = 12'(DEPTH + 1); cyc();
    chk("len too big s_ready", 64'(bus.s_ready), 64'(0));

`ifdef WT_BUF_PARITY_EN
    dut.g_bank[2].u_ram.mem[0][3] = ~dut.g_bank[2].u_ram.mem[0][3];
    mdl[0][0][2*DW+3] = ~mdl[0][0][2*DW+3];
    bad[0][0] = 4'b0100;
    clr(); bus.rd_en = 1; cyc();
    chk("parity lit", 64'(bus.rd_perr), 64'(4'b0100));
    chk("parity rd_valid", 64'(bus.rd_valid), 64'(1));
`endif

    for (int t = 0; t < 6000; t++) begin
      rst_n = ($urandom % 1500) != 0;
      bus.csen = ($urandom % 10) != 0;
      bus.load_start = ($urandom % 8) == 0;
      r = int'($urandom % 100);
      bus.load_len = r < 5 ? 12'd0 : r < 10 ? 12'(DEPTH + 1) : r < 11 ? 12'(DEPTH) : 12'($urandom_range(1, 16));
      bus.s_valid = ($urandom % 10) < 7;
      bus.s_data = $urandom;
      bus.swap = ($urandom % 12) == 0;
      bus.rd_en = ($urandom % 10) < 6;
      bus.rd_addr = ($urandom % 4) == 0 ? 11'($urandom_range(0, DEPTH - 1)) : 11'($urandom_range(0, 15));
      cyc();
    end

    clr(); rst_n = 0; cyc();
    rst_n = 1; bus.load_start = 1; bus.load_len = 12'd10; cyc();
    for (int i = 0; i < 3; i++) begin
      clr(); bus.s_valid = 1; bus.s_data = 32'h11110000 + i; cyc();
    end
    clr(); rst_n = 0; cyc();
    chk("midload rst s_ready", 64'(bus.s_ready), 64'(0));
    chk("midload rst shadow_full", 64'(bus.shadow_full), 64'(0));
    chk("midload rst active_sel", 64'(bus.active_sel), 64'(0));
    chk("midload rst load_done", 64'(bus.load_done), 64'(0));
    rst_n = 1; cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wt_pingpong_buffer.md
# wt_pingpong_buffer

Parametrised, double-buffered multi-bank weight store for the ECG accelerator: one half (the active half) feeds the PE array, while a streaming loader fills the other half (the shadow half) with the next layer's weights over a valid/ready channel. A swap command exchanges the halves, so weight loading overlaps computation. Loading is fully synthesizable; no file-based initialisation is used in any mode.

## Interface
- NUM_BANKS, 4, banks read in parallel (one word per bank per address)
- DATA_WIDTH, 8, bits per weight word
- ADDR_WIDTH, 11, address bits within one half
- DATA_DEPTH, 2048, words per bank per half (≤ 2^ADDR_WIDTH)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- csen  in  1  chip select; gates reads and load beats
- load_start  in  1  pulse: begin filling shadow half
- load_len  in  ADDR_WIDTH+1  words per bank to load, 1..DATA_DEPTH; sampled with load_start
- s_valid  in  1  load beat valid
- s_ready  out  1  load beat accepted when s_valid&s_ready
- s_data  in  NUM_BANKS*DATA_WIDTH  one word per bank, bank 0 in LSBs
- load_done  out  1  one-cycle pulse after final beat written
- shadow_full  out  1  shadow half loaded, awaiting swap
- swap  in  1  pulse: exchange halves
- swap_err  out  1  one-cycle pulse: swap rejected
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address in active half
- rd_data  out  NUM_BANKS*DATA_WIDTH  read data
- rd_valid  out  1  rd_data valid
- active_sel  out  1  index of active half

## Operation
- Loader FSM states: IDLE, LOAD, FULL.
- IDLE: load_start with load_len in 1..DATA_DEPTH → LOAD, wr_cnt=0, len latched. load_len=0 or >DATA_DEPTH → ignored, remain IDLE.
- LOAD: s_ready = csen. Each accepted beat writes s_data to all banks at {~active_sel, wr_cnt}; wr_cnt++. Beat with wr_cnt==len-1 → load_done pulse, → FULL. load_start in LOAD is ignored.
- FULL: shadow_full=1, s_ready=0. swap → active_sel toggles, → IDLE. load_start ignored.
- swap in IDLE or LOAD → swap_err pulse, no state change.
- Read: rd_en&csen → rd_data = active-half words at rd_addr, rd_valid=1 next cycle; otherwise rd_data=0, rd_valid=0.
- Read and swap in the same cycle: the read uses the pre-swap active_sel.
- Read and write never conflict (different halves); no bypass.

## Timing
- Reset: state IDLE, active_sel=0, s_ready=0, load_done=0, shadow_full=0, swap_err=0, rd_data=0, rd_valid=0. RAM contents are not reset.
- Read latency 1 cycle, fully pipelined, one read per cycle.
- load_start→s_ready high: 1 cycle. Final beat→load_done: next cycle, shadow_full high in the same cycle.
- Swap takes effect for reads issued the cycle after the swap; a load_start may be accepted that same cycle.
- Reset mid-load: load aborted, shadow contents undefined, shadow_full=0.
- Throughput: one beat per cycle; load of N words takes N cycles at full s_valid.

## Configuration
- WT_BUF_PARITY_EN defined: each stored word carries one even-parity bit computed at write time; output rd_perr [NUM_BANKS-1:0] (reset 0) is valid with rd_valid, one bit per bank set on a mismatch. rd_data is unaffected.
- Undefined: no parity storage, no rd_perr port.

## Structure
- Package wt_buf_pkg: loader state enum (IDLE/LOAD/FULL), default parameter constants, helper function for the parity bit.
- Sub-module wt_bank_ram: simple dual-port block RAM (one write, one registered read) of depth 2*DATA_DEPTH, instantiated NUM_BANKS times; the top holds the FSM, counters, and read gating.

## Test plan
- Reset, then rd_en at addr 0 → rd_data=0 until a load and swap; active_sel=0, all flags 0.
- load_start len=4, beats 0x04030201..0x04030204 with no gaps → load_done in cycle 5 after start, shadow_full=1; swap; read addrs 0..3 → same words, 1-cycle latency.
- Reading the active half while loading the shadow half with s_valid toggling → read data unchanged; wr_cnt advances only on handshakes.
- swap during LOAD → swap_err pulse, active_sel unchanged; load_len=0 → stays IDLE, s_ready=0.
- Same-cycle swap+rd_en → data from the old half; the next read returns data from the new half.
- With WT_BUF_PARITY_EN defined, force a bit flip in bank 2 → rd_perr=4'b0100 together with rd_valid.
